// File: rtl/core_pkg.sv
// Shared decode/execute definitions for the 5-stage MIPS core.
package core_pkg;

  // Decoder control bundle carried from ID into EX.
  typedef struct packed {
    logic       regdst;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       ifsign;
    logic [5:0] aluop;
  } ctrl_t;

  // A bubble is an all-zero bundle: no writes, no memory access.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // ALU operation encodings produced by the decoder.
  localparam logic [5:0] ALUOP_MEM   = 6'b000000;
  localparam logic [5:0] ALUOP_RTYPE = 6'b000010;
  localparam logic [5:0] ALUOP_ADDI  = 6'b000011;
  localparam logic [5:0] ALUOP_ANDI  = 6'b000111;
  localparam logic [5:0] ALUOP_ORI   = 6'b001011;
  localparam logic [5:0] ALUOP_XORI  = 6'b001111;
  localparam logic [5:0] ALUOP_SLTI  = 6'b011011;
  localparam logic [5:0] ALUOP_LUI   = 6'b011111;
  localparam logic [5:0] ALUOP_SLTIU = 6'b100111;

endpackage

// File: rtl/load_use_hazard_unit.sv
// Combinational load-use hazard detection between the EX load and the ID
// instruction. A taken branch/jump suppresses the stall request because the
// ID instruction is being killed anyway.
module load_use_hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_alusrc,
  input  logic              i_id_memwrite,
  input  logic              i_flush,
  output logic              o_hazard,
  output logic              o_stall
);

  logic ex_is_load;
  logic id_uses_rt;
  logic src_match;

  // A load into $0 never produces a value anyone waits for; rt is only a
  // source for register-register ops and for store data.
  always_comb begin
    ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rt != '0);
    id_uses_rt = ~i_id_alusrc | i_id_memwrite;
    src_match  = (i_ex_rt == i_id_rs) | ((i_ex_rt == i_id_rt) & id_uses_rt);
    o_hazard   = ex_is_load & i_id_valid & src_match;
    o_stall    = o_hazard & ~i_flush;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// global hold and a saturating stall-cycle counter.
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_regdst,
  input  logic              i_memread,
  input  logic              i_memtoreg,
  input  logic              i_memwrite,
  input  logic              i_alusrc,
  input  logic              i_regwrite,
  input  logic              i_ifsign,
  input  logic [5:0]        i_aluop,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_pc4,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_id_valid,
  input  logic              i_flush,
  input  logic              i_hold,
  output logic              o_regdst,
  output logic              o_memread,
  output logic              o_memtoreg,
  output logic              o_memwrite,
  output logic              o_alusrc,
  output logic              o_regwrite,
  output logic              o_ifsign,
  output logic [5:0]        o_aluop,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_imm,
  output logic [DATA_W-1:0] o_pc4,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_ex_valid,
  output logic              o_stall,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0]  pc4_q, pc4_d;
  logic [REG_AW-1:0]  rs_q, rs_d;
  logic [REG_AW-1:0]  rt_q, rt_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic               ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hazard;

  assign id_ctrl = '{regdst: i_regdst, memread: i_memread, memtoreg: i_memtoreg,
                     memwrite: i_memwrite, alusrc: i_alusrc, regwrite: i_regwrite,
                     ifsign: i_ifsign, aluop: i_aluop};

  load_use_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_ex_valid   (ex_valid_q),
    .i_ex_memread (ctrl_q.memread),
    .i_ex_rt      (rt_q),
    .i_id_valid   (i_id_valid),
    .i_id_rs      (i_rs),
    .i_id_rt      (i_rt),
    .i_id_alusrc  (i_alusrc),
    .i_id_memwrite(i_memwrite),
    .i_flush      (i_flush),
    .o_hazard     (hazard),
    .o_stall      (o_stall)
  );

  // Next-state: flush beats hold beats hazard beats normal capture.
  always_comb begin
    ctrl_d     = ctrl_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    pc4_d      = pc4_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    ex_valid_d = ex_valid_q;
    cnt_d      = cnt_q;
    if (i_flush || (!i_hold && hazard)) begin
      ctrl_d     = CTRL_BUBBLE;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      pc4_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      ex_valid_d = 1'b0;
      // Only real load-use stalls are counted, never flush bubbles.
      if (!i_flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end else if (!i_hold) begin
      ctrl_d     = i_id_valid ? id_ctrl : CTRL_BUBBLE;
      rs_data_d  = i_rs_data;
      rt_data_d  = i_rt_data;
      imm_d      = i_imm;
      pc4_d      = i_pc4;
      rs_d       = i_rs;
      rt_d       = i_rt;
      rd_d       = i_rd;
      ex_valid_d = i_id_valid;
    end
  end

  // State register; reset leaves a bubble in EX and clears the counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      pc4_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      pc4_q      <= pc4_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_regdst    = ctrl_q.regdst;
  assign o_memread   = ctrl_q.memread;
  assign o_memtoreg  = ctrl_q.memtoreg;
  assign o_memwrite  = ctrl_q.memwrite;
  assign o_alusrc    = ctrl_q.alusrc;
  assign o_regwrite  = ctrl_q.regwrite;
  assign o_ifsign    = ctrl_q.ifsign;
  assign o_aluop     = ctrl_q.aluop;
  assign o_rs_data   = rs_data_q;
  assign o_rt_data   = rt_data_q;
  assign o_imm       = imm_q;
  assign o_pc4       = pc4_q;
  assign o_rs        = rs_q;
  assign o_rt        = rt_q;
  assign o_rd        = rd_q;
  assign o_ex_valid  = ex_valid_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for the ID/EX pipeline register. A second instance with
// a 4-bit counter shares the stimulus so the saturation boundary is reached
// in a few dozen stalls instead of 65536.
module tb_id_ex_stage_reg;
  import core_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_regdst, i_memread, i_memtoreg, i_memwrite, i_alusrc, i_regwrite, i_ifsign;
  logic [5:0]  i_aluop;
  logic [31:0] i_rs_data, i_rt_data, i_imm, i_pc4;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic        i_id_valid, i_flush, i_hold;

  logic        o_regdst, o_memread, o_memtoreg, o_memwrite, o_alusrc, o_regwrite, o_ifsign;
  logic [5:0]  o_aluop;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc4;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_ex_valid, o_stall;
  logic [15:0] o_stall_cnt;

  logic        s_regdst, s_memread, s_memtoreg, s_memwrite, s_alusrc, s_regwrite, s_ifsign;
  logic [5:0]  s_aluop;
  logic [31:0] s_rs_data, s_rt_data, s_imm, s_pc4;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_ex_valid, s_stall;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 i_clk = ~i_clk;

  id_ex_stage_reg dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_regdst(i_regdst), .i_memread(i_memread), .i_memtoreg(i_memtoreg),
    .i_memwrite(i_memwrite), .i_alusrc(i_alusrc), .i_regwrite(i_regwrite),
    .i_ifsign(i_ifsign), .i_aluop(i_aluop),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_pc4(i_pc4),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_id_valid(i_id_valid), .i_flush(i_flush), .i_hold(i_hold),
    .o_regdst(o_regdst), .o_memread(o_memread), .o_memtoreg(o_memtoreg),
    .o_memwrite(o_memwrite), .o_alusrc(o_alusrc), .o_regwrite(o_regwrite),
    .o_ifsign(o_ifsign), .o_aluop(o_aluop),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc4(o_pc4),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_ex_valid(o_ex_valid), .o_stall(o_stall), .o_stall_cnt(o_stall_cnt)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_regdst(i_regdst), .i_memread(i_memread), .i_memtoreg(i_memtoreg),
    .i_memwrite(i_memwrite), .i_alusrc(i_alusrc), .i_regwrite(i_regwrite),
    .i_ifsign(i_ifsign), .i_aluop(i_aluop),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_pc4(i_pc4),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_id_valid(i_id_valid), .i_flush(i_flush), .i_hold(i_hold),
    .o_regdst(s_regdst), .o_memread(s_memread), .o_memtoreg(s_memtoreg),
    .o_memwrite(s_memwrite), .o_alusrc(s_alusrc), .o_regwrite(s_regwrite),
    .o_ifsign(s_ifsign), .o_aluop(s_aluop),
    .o_rs_data(s_rs_data), .o_rt_data(s_rt_data), .o_imm(s_imm), .o_pc4(s_pc4),
    .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd),
    .o_ex_valid(s_ex_valid), .o_stall(s_stall), .o_stall_cnt(s_stall_cnt)
  );

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    {i_regdst, i_memread, i_memtoreg, i_memwrite, i_alusrc, i_regwrite, i_ifsign} = '0;
    i_aluop = '0; i_rs_data = '0; i_rt_data = '0; i_imm = '0; i_pc4 = '0;
    i_rs = '0; i_rt = '0; i_rd = '0; i_id_valid = 1'b0; i_flush = 1'b0; i_hold = 1'b0;
  endtask

  task automatic drive_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    clear_inputs();
    i_regwrite = 1'b1; i_alusrc = 1'b1; i_ifsign = 1'b1; i_aluop = ALUOP_ADDI;
    i_rs = rs; i_rt = rt; i_imm = imm; i_pc4 = 32'h0000_0104; i_id_valid = 1'b1;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    clear_inputs();
    i_memread = 1'b1; i_memtoreg = 1'b1; i_alusrc = 1'b1; i_regwrite = 1'b1;
    i_aluop = ALUOP_MEM; i_rs = rs; i_rt = rt; i_imm = 32'h10; i_id_valid = 1'b1;
  endtask

  task automatic drive_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clear_inputs();
    i_regdst = 1'b1; i_regwrite = 1'b1; i_aluop = ALUOP_RTYPE;
    i_rs = rs; i_rt = rt; i_rd = rd; i_rs_data = 32'h0000_AAAA; i_rt_data = 32'h0000_5555;
    i_pc4 = 32'h0000_0200; i_id_valid = 1'b1;
  endtask

  task automatic drive_sw(input logic [4:0] rs, input logic [4:0] rt);
    clear_inputs();
    i_memwrite = 1'b1; i_alusrc = 1'b1; i_aluop = ALUOP_MEM;
    i_rs = rs; i_rt = rt; i_imm = 32'h8; i_id_valid = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    drive_addi(5'd1, 5'd8, 32'h1234_5678);
    i_rs_data = 32'hDEAD_BEEF; i_rt_data = 32'hCAFE_F00D;
    #3 i_rst_n = 1'b1;
    tick();
    checks++; if (o_ex_valid !== 1'b1) begin errors++; $display("FAIL reset_preload ex_valid got %b exp 1", o_ex_valid); end
    // Mid-cycle, nowhere near a clock edge.
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b exp 0", o_ex_valid); end
    checks++; if ({o_regwrite, o_alusrc, o_ifsign, o_aluop} !== 9'd0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {o_regwrite, o_alusrc, o_ifsign, o_aluop}); end
    checks++; if ({o_imm, o_rs_data, o_rt_data, o_pc4} !== 128'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {o_imm, o_rs_data, o_rt_data, o_pc4}); end
    checks++; if ({o_rs, o_rt, o_rd} !== 15'd0) begin errors++; $display("FAIL reset_idx got %h exp 0", {o_rs, o_rt, o_rd}); end
    checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", o_stall_cnt); end
    tick();
    i_rst_n = 1'b1;
    clear_inputs();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back_addi();
    drive_addi(5'd1, 5'd8, 32'h0000_0005);
    tick();
    checks++; if ({o_regwrite, o_alusrc, o_ex_valid} !== 3'b111) begin errors++; $display("FAIL addi1_ctrl got %b exp 111", {o_regwrite, o_alusrc, o_ex_valid}); end
    checks++; if (o_imm !== 32'h5) begin errors++; $display("FAIL addi1_imm got %h exp 00000005", o_imm); end
    checks++; if (o_aluop !== 6'b000011 || o_rt !== 5'd8) begin errors++; $display("FAIL addi1_op_rt got %b/%0d exp 000011/8", o_aluop, o_rt); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL addi1_stall got %b exp 0", o_stall); end
    drive_addi(5'd2, 5'd10, 32'h0000_0007);
    tick();
    checks++; if (o_imm !== 32'h7 || o_rt !== 5'd10 || o_ex_valid !== 1'b1) begin errors++; $display("FAIL addi2 got imm %h rt %0d v %b exp 7/10/1", o_imm, o_rt, o_ex_valid); end
    $display("test_back_to_back_addi done");
  endtask

  task automatic test_load_use_rtype();
    drive_lw(5'd2, 5'd9);
    tick();
    drive_rtype(5'd9, 5'd3, 5'd11);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", o_stall); end
    tick();
    exp_cnt++;
    checks++; if (o_ex_valid !== 1'b0 || o_regwrite !== 1'b0 || o_rs !== 5'd0) begin errors++; $display("FAIL lu_bubble got v %b rw %b rs %0d exp 0/0/0", o_ex_valid, o_regwrite, o_rs); end
    checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", o_stall_cnt); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle got %b exp 0", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b1 || o_regdst !== 1'b1 || o_rd !== 5'd11 || o_rs_data !== 32'h0000_AAAA) begin errors++; $display("FAIL lu_capture got v %b rd %0d d %h exp 1/11/0000aaaa", o_ex_valid, o_rd, o_rs_data); end
    $display("test_load_use_rtype done");
  endtask

  task automatic test_no_false_hazard();
    drive_lw(5'd2, 5'd9);
    tick();
    drive_addi(5'd1, 5'd9, 32'h1);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL nf_addi_dest got %b exp 0", o_stall); end
    drive_lw(5'd2, 5'd0);
    tick();
    drive_rtype(5'd0, 5'd0, 5'd12);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL nf_zero_reg got %b exp 0", o_stall); end
    checks++; if (o_stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL nf_cnt got %0d exp %0d", o_stall_cnt, exp_cnt); end
    $display("test_no_false_hazard done");
  endtask

  task automatic test_store_hazard();
    drive_lw(5'd2, 5'd4);
    tick();
    drive_sw(5'd5, 5'd4);
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL st_stall got %b exp 1", o_stall); end
    tick();
    exp_cnt++;
    checks++; if (o_stall_cnt !== 16'(exp_cnt) || o_ex_valid !== 1'b0) begin errors++; $display("FAIL st_bubble got cnt %0d v %b exp %0d/0", o_stall_cnt, o_ex_valid, exp_cnt); end
    tick();
    checks++; if (o_memwrite !== 1'b1 || o_ex_valid !== 1'b1 || o_rt !== 5'd4) begin errors++; $display("FAIL st_capture got mw %b v %b rt %0d exp 1/1/4", o_memwrite, o_ex_valid, o_rt); end
    $display("test_store_hazard done");
  endtask

  task automatic test_flush_priority();
    drive_lw(5'd2, 5'd6);
    tick();
    drive_rtype(5'd6, 5'd1, 5'd13);
    i_flush = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_regdst !== 1'b0 || o_rd !== 5'd0) begin errors++; $display("FAIL fl_bubble got v %b rd %0d exp 0/0", o_ex_valid, o_rd); end
    checks++; if (o_stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL fl_cnt got %0d exp %0d", o_stall_cnt, exp_cnt); end
    drive_addi(5'd1, 5'd14, 32'h99);
    i_flush = 1'b1;
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_imm !== 32'h0 || o_regwrite !== 1'b0) begin errors++; $display("FAIL fl_plain got v %b imm %h exp 0/0", o_ex_valid, o_imm); end
    $display("test_flush_priority done");
  endtask

  task automatic test_hold();
    drive_addi(5'd1, 5'd12, 32'h33);
    tick();
    drive_addi(5'd1, 5'd13, 32'h44);
    i_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_imm !== 32'h33 || o_rt !== 5'd12 || o_ex_valid !== 1'b1) begin errors++; $display("FAIL hold_freeze%0d got imm %h rt %0d exp 33/12", k, o_imm, o_rt); end
    end
    i_hold = 1'b0;
    tick();
    checks++; if (o_imm !== 32'h44 || o_rt !== 5'd13) begin errors++; $display("FAIL hold_resume got imm %h rt %0d exp 44/13", o_imm, o_rt); end
    drive_lw(5'd2, 5'd7);
    tick();
    drive_rtype(5'd7, 5'd1, 5'd15);
    i_hold = 1'b1;
    tick();
    checks++; if (o_stall !== 1'b1 || o_memread !== 1'b1 || o_rt !== 5'd7) begin errors++; $display("FAIL hold_hazard got st %b mr %b rt %0d exp 1/1/7", o_stall, o_memread, o_rt); end
    checks++; if (o_stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL hold_cnt got %0d exp %0d", o_stall_cnt, exp_cnt); end
    i_hold = 1'b0;
    tick();
    exp_cnt++;
    checks++; if (o_stall_cnt !== 16'(exp_cnt) || o_ex_valid !== 1'b0) begin errors++; $display("FAIL hold_release got cnt %0d v %b exp %0d/0", o_stall_cnt, o_ex_valid, exp_cnt); end
    tick();
    $display("test_hold done");
  endtask

  task automatic test_saturation();
    checks++; if (s_stall_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL sat_pre got %0d exp %0d", s_stall_cnt, exp_cnt); end
    drive_lw(5'd9, 5'd9);
    tick();
    for (int k = 0; k < 20; k++) begin
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL sat_stall%0d got %b exp 1", k, o_stall); end
      tick();
      exp_cnt++;
      tick();
    end
    checks++; if (o_stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_wide got %0d exp %0d", o_stall_cnt, exp_cnt); end
    checks++; if (s_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_narrow got %h exp f", s_stall_cnt); end
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid_stall();
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rs_pre_stall got %b exp 1", o_stall); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_ex_valid !== 1'b0 || o_memread !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL rs_bubble got v %b mr %b st %b exp 0/0/0", o_ex_valid, o_memread, o_stall); end
    checks++; if (o_stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin errors++; $display("FAIL rs_cnt got %0d/%0d exp 0/0", o_stall_cnt, s_stall_cnt); end
    tick();
    i_rst_n = 1'b1;
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    test_reset();
    test_back_to_back_addi();
    test_load_use_rtype();
    test_no_false_hazard();
    test_store_hazard();
    test_flush_priority();
    test_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the decode control unit in the 5-stage MIPS core.
- Latches the decoder control bundle with register operands, immediate, register indices and PC+4.
- Detects load-use hazards against the instruction currently in EX, and inserts bubbles on load-use stalls and branch flushes.
- Keeps a saturating count of hazard stall cycles for performance debug.

Parameters:
- DATA_W, 32, datapath width (operands, immediate, PC).
- REG_AW, 5, register index width.
- CNT_W, 16, stall counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_regdst, i_memread, i_memtoreg, i_memwrite, i_alusrc, i_regwrite, i_ifsign  in  1 each  decoder control bits for the ID instruction.
- i_aluop  in  6  decoder ALU op.
- i_rs_data, i_rt_data  in  DATA_W  register file read data.
- i_imm  in  DATA_W  sign/zero-extended immediate.
- i_pc4  in  DATA_W  PC+4 of the ID instruction.
- i_rs, i_rt, i_rd  in  REG_AW  ID instruction fields.
- i_id_valid  in  1  ID slot holds a real instruction.
- i_flush  in  1  branch/jump taken; kill the ID instruction.
- i_hold  in  1  global freeze (memory wait).
- o_regdst, o_memread, o_memtoreg, o_memwrite, o_alusrc, o_regwrite, o_ifsign  out  1 each  registered control to EX.
- o_aluop  out  6  registered ALU op.
- o_rs_data, o_rt_data, o_imm, o_pc4  out  DATA_W  registered data.
- o_rs, o_rt, o_rd  out  REG_AW  registered indices (forwarding unit and dest mux).
- o_ex_valid  out  1  EX slot holds a real instruction.
- o_stall  out  1  combinational; freeze PC and IF/ID this cycle.
- o_stall_cnt  out  CNT_W  saturating hazard-stall count.

Behaviour:
- Reset: async on i_rst_n low. All registered outputs and o_stall_cnt go to 0, giving a bubble in EX.
- Hazard, combinational, is asserted when all of the following hold:
  - o_ex_valid = 1, o_memread = 1 and o_rt != 0;
  - i_id_valid = 1;
  - o_rt == i_rs, or (o_rt == i_rt and the ID instruction uses rt as a source, i.e. i_alusrc == 0 or i_memwrite == 1).
- o_stall = hazard & ~i_flush.
- Per rising edge, first match wins:
  - i_flush: load bubble. All control bits 0, aluop 0, o_ex_valid 0, data and index fields 0.
  - i_hold: retain every register. The counter does not change.
  - hazard: load bubble as above. o_stall_cnt increments, saturating at all-ones.
  - otherwise: capture every input. o_ex_valid <= i_id_valid, but control bits are forced to 0 when i_id_valid = 0.
- Latency: 1 cycle from inputs to outputs.
- A load-use stall lasts exactly one cycle. The next cycle EX holds the bubble (o_ex_valid = 0), so hazard deasserts.
- Hazard on $0 (o_rt = 0) is never flagged.
- i_flush together with a hazard: a bubble is loaded, o_stall = 0 and the counter does not increment.
- i_hold together with a hazard: o_stall stays asserted and the register is unchanged.
- Reset asserted mid-stall: the bubble takes effect immediately and the counter clears.

Decomposition:
- Shared package core_pkg:
  - ctrl_t packed struct holding the 7 control bits plus aluop[5:0];
  - CTRL_BUBBLE constant (all zero);
  - aluop encoding constants: ALUOP_MEM 6'b000000, ALUOP_RTYPE 6'b000010, ALUOP_ADDI 6'b000011, ALUOP_ANDI 6'b000111, ALUOP_ORI 6'b001011, ALUOP_XORI 6'b001111, ALUOP_SLTI 6'b011011, ALUOP_LUI 6'b011111, ALUOP_SLTIU 6'b100111.
- One sub-module, load_use_hazard_unit: purely combinational hazard/o_stall logic, reused later by the branch-compare stage.

Test Plan:
- Reset: hold i_rst_n = 0 mid-cycle with non-zero inputs. All outputs read 0 immediately, without waiting for a clock edge.
- Back-to-back ADDI: ID addi with i_rt = 8, i_imm = 0x00000005, i_aluop = 6'b000011, i_id_valid = 1. Next edge: o_regwrite = 1, o_alusrc = 1, o_imm = 5, o_ex_valid = 1 and o_stall = 0.
- Load-use R-type: EX holds lw with o_rt = 9. ID holds R-type with i_rs = 9, i_alusrc = 0. Expect o_stall = 1 for one cycle, then a bubble in EX, then the R-type captured on the following edge; o_stall_cnt = 1.
- No false hazards:
  - EX lw with o_rt = 9, ID addi with i_rt = 9 (alusrc = 1, rt is the destination): o_stall = 0.
  - Same case with the lw having o_rt = 0: o_stall = 0.
- Store data hazard: EX lw with o_rt = 4, ID sw with i_rt = 4 (i_memwrite = 1) -> o_stall = 1.
- Priorities:
  - Flush during a hazard: o_stall = 0, a bubble is loaded and the counter is unchanged.
  - i_hold for 3 cycles: outputs stay frozen, then capture resumes.
  - Force 2^CNT_W stalls: o_stall_cnt saturates at 0xFFFF.
